// File: rtl/trace_capture_ctrl_if.sv
// Trace-buffer BRAM port bundle: port A write side, port B read side.
// master = capture controller, slave = BRAM.
interface trace_capture_ctrl_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 256
);
  logic [ADDR_W-1:0] trace_buf_bram_addra;
  logic [DATA_W-1:0] trace_buf_bram_data_in;
  logic              trace_buf_we;
  logic              trace_buf_en;
  logic [ADDR_W-1:0] trace_buf_bram_addrb;
  logic [DATA_W-1:0] trace_buf_bram_dout;

  modport master (
    output trace_buf_bram_addra, trace_buf_bram_data_in, trace_buf_we,
    output trace_buf_en, trace_buf_bram_addrb,
    input  trace_buf_bram_dout
  );
  modport slave (
    input  trace_buf_bram_addra, trace_buf_bram_data_in, trace_buf_we,
    input  trace_buf_en, trace_buf_bram_addrb,
    output trace_buf_bram_dout
  );
endinterface

// File: rtl/trace_capture_ctrl.sv
// Trace capture sequencer: circular pre-trigger history, programmed post-trigger
// tail, then freeze and serve host reads relative to the oldest stored sample.
module trace_capture_ctrl #(
  parameter int VECTOR_DATA_WIDTH    = 192,
  parameter int TRACE_BUF_DATA_WIDTH = 256,
  parameter int TRACE_BUF_ADDR_WIDTH = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            arm,
  input  logic                            abort,
  input  logic                            sample_valid,
  input  logic [VECTOR_DATA_WIDTH-1:0]    vctr_fifo_data_out,
  input  logic                            trigger,
  input  logic [TRACE_BUF_ADDR_WIDTH-1:0] post_trig_count,
  input  logic                            rd_req,
  input  logic [TRACE_BUF_ADDR_WIDTH-1:0] rd_offset,
  trace_capture_ctrl_if.master            bram,
  output logic                            rd_valid,
  output logic [TRACE_BUF_DATA_WIDTH-1:0] rd_data,
  output logic [1:0]                      state,
  output logic                            capture_done,
  output logic [TRACE_BUF_ADDR_WIDTH-1:0] trig_addr,
  output logic [TRACE_BUF_ADDR_WIDTH:0]   sample_count
);
  localparam int AW = TRACE_BUF_ADDR_WIDTH;
  localparam int DW = TRACE_BUF_DATA_WIDTH;
  localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          wrapped_q, wrapped_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [AW-1:0] trig_addr_q, trig_addr_d;
  logic [AW:0]   sample_count_q, sample_count_d;
  logic [AW-1:0] addra_q, addra_d;
  logic [DW-1:0] data_in_q, data_in_d;
  logic          we_q, we_d;
  logic [AW-1:0] addrb_q, addrb_d;
  logic [2:1]    vld_pipe_q, vld_pipe_d;

  logic          accept_arm, wr_fire, trig_fire, rd_fire;
  logic [AW-1:0] oldest;

  // Priority abort > arm > trigger > sample_valid is encoded in these qualifiers.
  always_comb begin
    accept_arm = arm & ~abort & ((state_q == S_IDLE) | (state_q == S_DONE));
    wr_fire    = sample_valid & ~abort & ((state_q == S_ARMED) | (state_q == S_POST));
    trig_fire  = wr_fire & trigger & (state_q == S_ARMED);
    rd_fire    = rd_req & ~abort & ~arm & (state_q == S_DONE);
    oldest     = wrapped_q ? wr_ptr_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      wrapped_q      <= 1'b0;
      post_cnt_q     <= '0;
      trig_addr_q    <= '0;
      sample_count_q <= '0;
      addra_q        <= '0;
      data_in_q      <= '0;
      we_q           <= 1'b0;
      addrb_q        <= '0;
      vld_pipe_q     <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      wrapped_q      <= wrapped_d;
      post_cnt_q     <= post_cnt_d;
      trig_addr_q    <= trig_addr_d;
      sample_count_q <= sample_count_d;
      addra_q        <= addra_d;
      data_in_q      <= data_in_d;
      we_q           <= we_d;
      addrb_q        <= addrb_d;
      vld_pipe_q     <= vld_pipe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (accept_arm) state_d = S_ARMED;
        S_ARMED: if (trig_fire)  state_d = (post_cnt_q == '0) ? S_DONE : S_POST;
        S_POST:  if (wr_fire && post_cnt_q == AW'(1)) state_d = S_DONE;
        S_DONE:  if (accept_arm) state_d = S_ARMED;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    wrapped_d      = wrapped_q;
    post_cnt_d     = post_cnt_q;
    trig_addr_d    = trig_addr_q;
    sample_count_d = sample_count_q;
    addra_d        = addra_q;
    data_in_d      = data_in_q;
    we_d           = wr_fire;
    addrb_d        = rd_fire ? oldest + rd_offset : addrb_q;
    vld_pipe_d     = {vld_pipe_q[1], rd_fire};

    if (accept_arm) begin
      wr_ptr_d       = '0;
      wrapped_d      = 1'b0;
      post_cnt_d     = post_trig_count;
      sample_count_d = '0;
    end else if (wr_fire) begin
      addra_d   = wr_ptr_q;
      data_in_d = DW'(vctr_fifo_data_out);
      wr_ptr_d  = wr_ptr_q + AW'(1);
      if (wr_ptr_q == '1) wrapped_d = 1'b1;
      sample_count_d = wrapped_d ? DEPTH_CNT : {1'b0, wr_ptr_d};
      if (trig_fire) trig_addr_d = wr_ptr_q;
      if (state_q == S_POST) post_cnt_d = post_cnt_q - AW'(1);
    end
  end

  // Read data is the BRAM output register itself, qualified so it reads 0 outside the valid beat.
  always_comb begin
    bram.trace_buf_bram_addra   = addra_q;
    bram.trace_buf_bram_data_in = data_in_q;
    bram.trace_buf_we           = we_q;
    bram.trace_buf_en           = 1'b1;
    bram.trace_buf_bram_addrb   = addrb_q;
    rd_valid                    = vld_pipe_q[2];
    rd_data                     = vld_pipe_q[2] ? bram.trace_buf_bram_dout : '0;
    state                       = state_q;
    capture_done                = (state_q == S_DONE);
    trig_addr                   = trig_addr_q;
    sample_count                = sample_count_q;
  end
endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl at DEPTH=16 with a behavioural BRAM.
module tb_trace_capture_ctrl;
  localparam int VW = 16;
  localparam int DW = 24;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, arm, abort, sample_valid, trigger, rd_req;
  logic [VW-1:0] vdata;
  logic [AW-1:0] post_trig_count, rd_offset;
  logic          rd_valid, capture_done;
  logic [DW-1:0] rd_data;
  logic [1:0]    state;
  logic [AW-1:0] trig_addr;
  logic [AW:0]   sample_count;

  int n_chk = 0;
  int n_pass = 0;
  int we_cnt = 0;
  logic [AW-1:0] wa_log[$];
  logic [DW-1:0] wd_log[$];

  trace_capture_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  trace_capture_ctrl #(
    .VECTOR_DATA_WIDTH(VW), .TRACE_BUF_DATA_WIDTH(DW), .TRACE_BUF_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .sample_valid(sample_valid),
    .vctr_fifo_data_out(vdata), .trigger(trigger), .post_trig_count(post_trig_count),
    .rd_req(rd_req), .rd_offset(rd_offset), .bram(bif), .rd_valid(rd_valid),
    .rd_data(rd_data), .state(state), .capture_done(capture_done),
    .trig_addr(trig_addr), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bif.trace_buf_we) mem[bif.trace_buf_bram_addra] <= bif.trace_buf_bram_data_in;
    bif.trace_buf_bram_dout <= mem[bif.trace_buf_bram_addrb];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (bif.trace_buf_we === 1'b1) begin
      we_cnt++;
      wa_log.push_back(bif.trace_buf_bram_addra);
      wd_log.push_back(bif.trace_buf_bram_data_in);
    end
  endtask

  task automatic send(input logic [VW-1:0] v, input logic trg);
    sample_valid = 1'b1; vdata = v; trigger = trg;
    step();
    sample_valid = 1'b0; trigger = 1'b0;
  endtask

  task automatic do_arm(input logic [AW-1:0] post);
    post_trig_count = post; arm = 1'b1;
    step();
    arm = 1'b0;
    we_cnt = 0; wa_log.delete(); wd_log.delete();
  endtask

  initial begin
    rst = 1'b1; arm = 0; abort = 0; sample_valid = 0; trigger = 0; rd_req = 0;
    vdata = '0; post_trig_count = '0; rd_offset = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_addra", 32'(bif.trace_buf_bram_addra), 0);
    chk("rst_addrb", 32'(bif.trace_buf_bram_addrb), 0);
    chk("rst_data_in", 32'(bif.trace_buf_bram_data_in), 0);
    chk("rst_we", 32'(bif.trace_buf_we), 0);
    chk("rst_en", 32'(bif.trace_buf_en), 1);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_done", 32'(capture_done), 0);
    chk("rst_trig_addr", 32'(trig_addr), 0);
    chk("rst_sample_count", 32'(sample_count), 0);

    // samples while idle are dropped
    for (int k = 0; k < 5; k++) send(VW'(16'h0050 + k), 1'b0);
    step();
    chk("idle_we_cnt", 32'(we_cnt), 0);
    chk("idle_state", 32'(state), 0);
    chk("idle_count", 32'(sample_count), 0);

    // post=3, trigger on the 6th of 10 samples
    do_arm(4'd3);
    chk("arm_state", 32'(state), 1);
    for (int k = 0; k < 10; k++) send(VW'(16'h0100 + k), k == 5);
    step();
    chk("p3_we_cnt", 32'(we_cnt), 9);
    for (int k = 0; k < 9 && k < wa_log.size(); k++) chk($sformatf("p3_addra%0d", k), 32'(wa_log[k]), k);
    if (wd_log.size() > 5) chk("p3_data5", 32'(wd_log[5]), 32'h000105);
    chk("p3_trig_addr", 32'(trig_addr), 5);
    chk("p3_state", 32'(state), 3);
    chk("p3_done", 32'(capture_done), 1);
    chk("p3_count", 32'(sample_count), 9);

    // three back-to-back reads, offsets 0,1,2
    rd_req = 1'b1; rd_offset = 4'd0; step();
    chk("rd_addrb0", 32'(bif.trace_buf_bram_addrb), 0);
    chk("rd_early", 32'(rd_valid), 0);
    rd_offset = 4'd1; step();
    chk("rd_v0", 32'(rd_valid), 1);
    chk("rd_d0", 32'(rd_data), 32'h000100);
    rd_offset = 4'd2; step();
    rd_req = 1'b0;
    chk("rd_v1", 32'(rd_valid), 1);
    chk("rd_d1", 32'(rd_data), 32'h000101);
    step();
    chk("rd_v2", 32'(rd_valid), 1);
    chk("rd_d2", 32'(rd_data), 32'h000102);
    step();
    chk("rd_v_end", 32'(rd_valid), 0);

    // wrap: 20 pre, trigger, 4 post -> samples 9..24 kept, oldest at addr 9
    do_arm(4'd4);
    chk("w_count_arm", 32'(sample_count), 0);
    for (int k = 0; k < 25; k++) send(VW'(16'h0200 + k), k == 20);
    step();
    chk("w_we_cnt", 32'(we_cnt), 25);
    chk("w_state", 32'(state), 3);
    chk("w_trig_addr", 32'(trig_addr), 4);
    chk("w_count", 32'(sample_count), 16);
    rd_req = 1'b1; rd_offset = 4'd0; step();
    chk("w_addrb0", 32'(bif.trace_buf_bram_addrb), 9);
    rd_offset = 4'd15; step();
    rd_req = 1'b0;
    chk("w_d0", 32'(rd_data), 32'h000209);
    step();
    chk("w_addrb15", 32'(bif.trace_buf_bram_addrb), 8);
    chk("w_d15", 32'(rd_data), 32'h000218);

    // post=0, trigger on the first sample
    do_arm(4'd0);
    send(VW'(16'h0300), 1'b1);
    chk("p0_we", 32'(bif.trace_buf_we), 1);
    chk("p0_addra", 32'(bif.trace_buf_bram_addra), 0);
    chk("p0_state", 32'(state), 3);
    chk("p0_trig_addr", 32'(trig_addr), 0);
    chk("p0_count", 32'(sample_count), 1);
    send(VW'(16'h0301), 1'b0);
    step();
    chk("p0_we_cnt", 32'(we_cnt), 1);

    // arm with a coincident sample in DONE: arm wins, no write
    post_trig_count = 4'd5; arm = 1'b1; sample_valid = 1'b1; vdata = VW'(16'h0400);
    step();
    arm = 1'b0; sample_valid = 1'b0;
    step();
    chk("arm_sv_state", 32'(state), 1);
    chk("arm_sv_we", 32'(bif.trace_buf_we), 0);
    chk("arm_sv_count", 32'(sample_count), 0);

    // abort mid-POST: in-flight write lands, nothing after
    we_cnt = 0;
    send(VW'(16'h0500), 1'b0);
    send(VW'(16'h0501), 1'b1);
    send(VW'(16'h0502), 1'b0);
    chk("ab_post_state", 32'(state), 2);
    chk("ab_inflight_we", 32'(bif.trace_buf_we), 1);
    abort = 1'b1; sample_valid = 1'b1; vdata = VW'(16'h0503);
    step();
    abort = 1'b0; sample_valid = 1'b0;
    chk("ab_we_after", 32'(bif.trace_buf_we), 0);
    chk("ab_state", 32'(state), 0);
    chk("ab_done", 32'(capture_done), 0);
    send(VW'(16'h0504), 1'b0);
    step();
    chk("ab_we_cnt", 32'(we_cnt), 3);
    rd_req = 1'b1; rd_offset = 4'd0; step();
    rd_req = 1'b0; step();
    chk("ab_rd_valid0", 32'(rd_valid), 0);
    step();
    chk("ab_rd_valid1", 32'(rd_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/trace_capture_ctrl.md
# trace_capture_ctrl

Sequencing controller for the trace-buffer BRAM. It arms on host command, writes 100 ns sample vectors from the vector FIFO circularly into port A as pre-trigger history, and on a qualified trigger writes a programmed number of post-trigger samples before freezing. It then serves host readout through port B, addressed relative to the oldest stored sample. It sits between the vector FIFO / 100 ns read strobe and the trace-buffer BRAM, under control of the AXI slave register block.

## Interface
- VECTOR_DATA_WIDTH, 192, width of one sample vector from the vector FIFO
- TRACE_BUF_DATA_WIDTH, 256, BRAM word width (must be ≥ VECTOR_DATA_WIDTH)
- TRACE_BUF_ADDR_WIDTH, 15, BRAM address width; DEPTH = 2^TRACE_BUF_ADDR_WIDTH
- clk  in  1  single clock for all logic
- rst  in  1  synchronous reset, active-high
- arm  in  1  single-cycle pulse; start a new capture
- abort  in  1  single-cycle pulse; return to IDLE
- sample_valid  in  1  100 ns strobe; vctr_fifo_data_out is valid this cycle
- vctr_fifo_data_out  in  VECTOR_DATA_WIDTH  sample vector
- trigger  in  1  trigger condition; only honoured when sample_valid=1
- post_trig_count  in  TRACE_BUF_ADDR_WIDTH  samples to write after the trigger sample; sampled on arm
- rd_req  in  1  host read request; only honoured in DONE
- rd_offset  in  TRACE_BUF_ADDR_WIDTH  read offset from the oldest sample
- trace_buf_bram_dout  in  TRACE_BUF_DATA_WIDTH  BRAM port B read data, 1-cycle latency
- trace_buf_bram_addra  out  TRACE_BUF_ADDR_WIDTH  port A write address
- trace_buf_bram_data_in  out  TRACE_BUF_DATA_WIDTH  registered sample, zero-extended
- trace_buf_we  out  1  port A write enable
- trace_buf_en  out  1  BRAM enable, constant 1
- trace_buf_bram_addrb  out  TRACE_BUF_ADDR_WIDTH  port B read address
- rd_valid  out  1  rd_data is valid
- rd_data  out  TRACE_BUF_DATA_WIDTH  read data returned to the host
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
- capture_done  out  1  high while state is DONE
- trig_addr  out  TRACE_BUF_ADDR_WIDTH  BRAM address holding the trigger sample
- sample_count  out  TRACE_BUF_ADDR_WIDTH+1  number of valid samples stored

## Operation
- wr_ptr is the next write address. wrapped is set when wr_ptr rolls over from DEPTH-1 to 0.
- IDLE:
  - arm → ARMED.
  - On entry to ARMED: wr_ptr=0, wrapped=0, sample_count=0, post_cnt latched from post_trig_count.
- ARMED:
  - Each sample_valid writes the sample at wr_ptr, then wr_ptr+1 (mod DEPTH).
  - sample_valid & trigger: the sample is written as in ARMED, trig_addr=wr_ptr.
  - Next state is DONE if post_cnt==0, else POST.
- POST:
  - Each sample_valid writes the sample and decrements post_cnt.
  - The write that takes post_cnt from 1 to 0 moves the FSM to DONE in the same cycle.
  - trigger is ignored in POST.
  - post_cnt ≤ DEPTH-1, so the trigger sample is never overwritten.
- DONE:
  - No writes; sample_valid is ignored.
  - oldest = wrapped ? wr_ptr : 0.
  - sample_count = wrapped ? DEPTH : wr_ptr; it saturates at DEPTH once wrapped.
  - arm → ARMED (new capture; previous data is invalidated).
- Readout: rd_req in DONE loads addrb = (oldest + rd_offset) mod DEPTH. rd_req outside DONE is dropped: no rd_valid.
- Priority: rst > abort > arm > trigger > sample_valid.
  - abort from any state → IDLE.
  - A write already registered still completes the next cycle; no new writes are accepted.
  - arm in ARMED or POST is ignored.

## Timing
- Reset values:
  - addra=0, addrb=0, data_in=0, we=0, rd_valid=0, rd_data=0.
  - state=IDLE, capture_done=0, trig_addr=0, sample_count=0.
  - Internal wr_ptr, post_cnt and wrapped are also 0.
- Write path, 1-cycle latency: sample_valid at cycle N → at N+1, we=1, addra = wr_ptr at N, data_in = {zeros, sample at N}.
- we is high for exactly one cycle per accepted sample. Back-to-back sample_valid produces back-to-back writes.
- State, trig_addr and sample_count update at the N+1 edge with the corresponding write.
- Read path: rd_req at cycle R → addrb valid at R+1 → BRAM dout at R+2 → rd_valid=1 and rd_data registered at R+2 edge, visible R+2.
- rd_valid is a 1-cycle pulse. One read may be issued per cycle, fully pipelined.
- Address arithmetic is unsigned and modulo DEPTH. The oldest+rd_offset carry is discarded.
- Simultaneous arm and sample_valid in IDLE/DONE: arm takes effect; that sample is not written.

## Test plan
- Reset, then 5 samples without arm → no we pulses; state=0, sample_count=0.
- Arm with post_trig_count=3; 10 samples with trigger on the 6th → 9 writes at addresses 0..8, trig_addr=5, state=3, sample_count=9.
- Arm with post=4 at DEPTH=16 (TRACE_BUF_ADDR_WIDTH=4); 20 pre-trigger samples, then trigger → wrapped, oldest=wr_ptr.
  - rd_offset=0 returns the sample written at addra (oldest + 0) mod 16.
  - sample_count=16.
- Arm with post=0; trigger coincident with the first sample → single write at 0, DONE the next cycle, trig_addr=0.
- abort in POST mid-stream → IDLE; no further we after the in-flight write; later rd_req gives no rd_valid.
- In DONE, rd_req on 3 consecutive cycles with offsets 0,1,2 → rd_valid on 3 consecutive cycles starting R+2; data matches in order.
